bcd_countdown_mux: RTL

- Parametrised countdown timer: DIGITS-wide BCD counter, loaded from a preset, decremented once per divided tick.
- Drives one multiplexed 7-segment bank: a single active-low common per digit plus the BCD nibble of the scanned digit, fed to the existing segment decoder.
- Raises an alarm output for the existing speaker driver when the count reaches zero.
- Adds start/pause/clear control, leading-zero blanking and timed alarm termination.

---
 rtl/bcd_timer_pkg.sv | 19 +
 rtl/bcd_dec_chain.sv | 42 ++++
 rtl/bcd_countdown_mux.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd_timer_pkg.sv
// Shared types, constants and helpers for the BCD countdown timer.
package bcd_timer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        ALARM = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Saturate a raw nibble to the largest legal BCD digit.
    function automatic logic [3:0] clamp_bcd(input logic [3:0] nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

endpackage

// File: rtl/bcd_dec_chain.sv
// Combinational DIGITS-wide BCD decrement with borrow; saturates at all-zeros.
module bcd_dec_chain
    import bcd_timer_pkg::*;
#(
    parameter int unsigned DIGITS = 2
) (
    input  logic [4*DIGITS-1:0] val_i,
    output logic [4*DIGITS-1:0] dec_o,
    output logic                is_zero_o,
    output logic                dec_zero_o
);

    logic [4*DIGITS-1:0] res;
    logic [3:0]          nib;
    logic                borrow;

    // Ripple the borrow from digit 0 upward; a zero digit becomes 9 and keeps borrowing.
    always_comb begin
        res    = '0;
        nib    = '0;
        borrow = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            nib = val_i[4*i +: 4];
            if (borrow) begin
                if (nib == 4'd0) begin
                    res[4*i +: 4] = BCD_MAX;
                end else begin
                    res[4*i +: 4] = nib - 4'd1;
                    borrow        = 1'b0;
                end
            end else begin
                res[4*i +: 4] = nib;
            end
        end
    end

    assign is_zero_o  = (val_i == '0);
    // All-zeros never wraps to all-nines.
    assign dec_o      = is_zero_o ? val_i : res;
    assign dec_zero_o = (dec_o == '0);

endmodule

// File: rtl/bcd_countdown_mux.sv
// BCD countdown timer with start/pause/clear, timed alarm and a multiplexed digit scan.
module bcd_countdown_mux
    import bcd_timer_pkg::*;
#(
    parameter int unsigned DIGITS      = 2,
    parameter int unsigned TICK_DIV    = 8388608,
    parameter int unsigned SCAN_DIV    = 131072,
    parameter int unsigned ALARM_TICKS = 5,
    parameter int unsigned BLANK_LZ    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                pause,
    input  logic                clear,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [DIGITS-1:0]   digit_sel,
    output logic [3:0]          bcd_out,
    output logic                blank,
    output logic                alarm,
    output logic                running,
    output logic                done
);

    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned AW = $clog2(ALARM_TICKS + 1);

    state_e              state_q;
    logic [4*DIGITS-1:0] count_q;
    logic [TW-1:0]       tick_cnt_q;
    logic [AW-1:0]       alarm_cnt_q;
    logic                alarm_q;
    logic                running_q;
    logic                done_q;

    logic [SW-1:0]       scan_cnt_q;
    logic [IW-1:0]       scan_idx_q;
    logic [DIGITS-1:0]   digit_sel_q;
    logic [3:0]          bcd_q;
    logic                blank_q;

    logic [4*DIGITS-1:0] count_dec;
    logic                count_zero;
    logic                dec_zero;
    logic [4*DIGITS-1:0] load_clamped;
    logic                tick;
    logic [TW-1:0]       tick_cnt_d;
    logic                scan_wrap;
    logic                scan_last;
    logic [DIGITS-1:0]   sel_onehot;
    logic [3:0]          sel_digit;
    logic                upper_zero;
    logic                blank_d;

    bcd_dec_chain #(
        .DIGITS(DIGITS)
    ) u_dec (
        .val_i     (count_q),
        .dec_o     (count_dec),
        .is_zero_o (count_zero),
        .dec_zero_o(dec_zero)
    );

    // Preset with every out-of-range nibble clamped to 9.
    always_comb begin
        load_clamped = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            load_clamped[4*i +: 4] = clamp_bcd(load_val[4*i +: 4]);
        end
    end

    assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

    // Control FSM, tick divider and alarm counter; status outputs follow the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            tick_cnt_q  <= '0;
            alarm_cnt_q <= '0;
            alarm_q     <= 1'b0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            alarm_q   <= (state_q == ALARM);
            running_q <= (state_q == RUN);
            done_q    <= (state_q == DONE);
            if (clear) begin
                count_q     <= load_clamped;
                tick_cnt_q  <= '0;
                alarm_cnt_q <= '0;
                state_q     <= IDLE;
                alarm_q     <= 1'b0;
                running_q   <= 1'b0;
                done_q      <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start && !pause) begin
                            if (count_zero) begin
                                state_q <= ALARM;
                                alarm_q <= 1'b1;
                            end else begin
                                state_q   <= RUN;
                                running_q <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            // Hold tick_cnt so the partial tick resumes later.
                            state_q   <= PAUSE;
                            running_q <= 1'b0;
                        end else begin
                            tick_cnt_q <= tick_cnt_d;
                            if (tick) begin
                                count_q <= count_dec;
                                if (dec_zero) begin
                                    state_q   <= ALARM;
                                    alarm_q   <= 1'b1;
                                    running_q <= 1'b0;
                                end
                            end
                        end
                    end
                    PAUSE: begin
                        if (start && !pause) begin
                            state_q   <= RUN;
                            running_q <= 1'b1;
                        end
                    end
                    ALARM: begin
                        count_q    <= '0;
                        tick_cnt_q <= tick_cnt_d;
                        if (tick) begin
                            if (alarm_cnt_q == AW'(ALARM_TICKS - 1)) begin
                                alarm_cnt_q <= AW'(ALARM_TICKS);
                                state_q     <= DONE;
                                alarm_q     <= 1'b0;
                                done_q      <= 1'b1;
                            end else begin
                                alarm_cnt_q <= alarm_cnt_q + AW'(1);
                            end
                        end
                    end
                    DONE: begin
                        count_q <= '0;
                    end
                    default: begin
                        state_q   <= IDLE;
                        alarm_q   <= 1'b0;
                        running_q <= 1'b0;
                        done_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign scan_wrap = (scan_cnt_q == SW'(SCAN_DIV - 1));
    assign scan_last = (scan_idx_q == IW'(DIGITS - 1));

    // Decode the scanned slot: one-hot select, its digit, and leading-zero status.
    always_comb begin
        sel_onehot = '0;
        sel_digit  = '0;
        upper_zero = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (IW'(i) == scan_idx_q) begin
                sel_onehot[i] = 1'b1;
                sel_digit     = count_q[4*i +: 4];
            end
            if ((IW'(i) >= scan_idx_q) && (count_q[4*i +: 4] != 4'd0)) begin
                upper_zero = 1'b0;
            end
        end
        blank_d = (BLANK_LZ != 0) && (scan_idx_q != '0) && upper_zero;
    end

    // Scan divider and registered display outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt_q  <= '0;
            scan_idx_q  <= '0;
            digit_sel_q <= ~DIGITS'(1);
            bcd_q       <= '0;
            blank_q     <= 1'b0;
        end else begin
            scan_cnt_q <= scan_wrap ? '0 : scan_cnt_q + SW'(1);
            if (scan_wrap) begin
                scan_idx_q <= scan_last ? '0 : scan_idx_q + IW'(1);
            end
            digit_sel_q <= ~sel_onehot;
            bcd_q       <= sel_digit;
            blank_q     <= blank_d;
        end
    end

    assign digit_sel = digit_sel_q;
    assign bcd_out   = bcd_q;
    assign blank     = blank_q;
    assign alarm     = alarm_q;
    assign running   = running_q;
    assign done      = done_q;

endmodule
